// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with synchronous IMEM, debug load port and a FQ_DEPTH-entry
// fetch queue toward decode. Optional halt detection on an all-ones word: IF_HALT_DETECT_EN.
module if_fetch_queue #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int FQ_DEPTH   = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_clk_en,
    input  logic                        i_id_ready,
    input  logic                        i_pcsrc,
    input  logic [ADDR_W-1:0]           i_beq_dir,
    input  logic                        i_jump,
    input  logic [ADDR_W-1:0]           i_jump_addr,
    input  logic                        i_jumpSel,
    input  logic [ADDR_W-1:0]           i_jr_jump_addr,
    input  logic                        i_write_en,
    input  logic [ADDR_W-1:0]           i_addr_wr,
    input  logic [DATA_W-1:0]           i_data,
    output logic                        o_valid,
    output logic [DATA_W-1:0]           o_instruction,
    output logic [ADDR_W-1:0]           o_pc_plus_4,
    output logic [$clog2(FQ_DEPTH):0]   o_fq_count,
    output logic                        o_halted
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    FQ_LIMIT = (CNT_W+1)'(FQ_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e              state_r;
    logic [ADDR_W-1:0]   pc_r;
    logic                inflight_r;
    logic [ADDR_W-1:0]   inflight_pc4_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [DATA_W-1:0]   mem_r [IMEM_DEPTH];
    logic [DATA_W-1:0]   fq_instr_r [FQ_DEPTH];
    logic [ADDR_W-1:0]   fq_pc4_r [FQ_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;

    logic                redirect_s;
    logic [ADDR_W-1:0]   target_s;
    logic                flush_s;
    logic                push_s;
    logic                pop_s;
    logic                halt_hit_s;
    logic                issue_s;
    logic [CNT_W:0]      occ_s;
    logic                unused_s;

    // Redirect, flush, push/pop and fetch-issue decisions for this cycle.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = {ADDR_W{1'b0}};
        halt_hit_s = 1'b0;
        if (i_jumpSel) begin
            target_s = i_jr_jump_addr;
        end else if (i_jump) begin
            target_s = i_jump_addr;
        end else begin
            target_s = i_beq_dir;
        end
        if (!i_write_en && (state_r == ST_FETCH || state_r == ST_HALT)) begin
            redirect_s = i_jumpSel | i_jump | i_pcsrc;
        end else begin
            redirect_s = 1'b0;
        end
        flush_s = i_write_en | redirect_s;
        // A read returns one cycle after issue, so a flush seen now discards the returning word.
        push_s  = inflight_r & ~flush_s;
        pop_s   = (count_r != {CNT_W{1'b0}}) & i_id_ready & ~flush_s;
`ifdef IF_HALT_DETECT_EN
        halt_hit_s = push_s & (rdata_r == {DATA_W{1'b1}});
`else
        halt_hit_s = 1'b0;
`endif
        occ_s   = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
        issue_s = (state_r == ST_FETCH) & ~flush_s & ~halt_hit_s & (occ_s < FQ_LIMIT);
    end

    // PC, state machine, in-flight tracking and queue storage.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r        <= ST_FETCH;
            pc_r           <= {ADDR_W{1'b0}};
            inflight_r     <= 1'b0;
            inflight_pc4_r <= {ADDR_W{1'b0}};
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            count_r        <= {CNT_W{1'b0}};
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_instr_r[i] <= {DATA_W{1'b0}};
                fq_pc4_r[i]   <= {ADDR_W{1'b0}};
            end
        end else if (i_clk_en) begin
            if (i_write_en) begin
                state_r <= ST_LOAD;
                pc_r    <= {ADDR_W{1'b0}};
            end else if (state_r == ST_LOAD) begin
                state_r <= ST_FETCH;
            end else if (redirect_s) begin
                state_r <= ST_FETCH;
                pc_r    <= target_s;
            end else begin
                if (issue_s) begin
                    pc_r <= pc_r + PC_STEP;
                end
                if (halt_hit_s) begin
                    state_r <= ST_HALT;
                end
            end

            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc4_r <= pc_r + PC_STEP;
            end

            if (flush_s) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
                count_r  <= {CNT_W{1'b0}};
            end else begin
                if (push_s) begin
                    fq_instr_r[wr_ptr_r] <= rdata_r;
                    fq_pc4_r[wr_ptr_r]   <= inflight_pc4_r;
                    wr_ptr_r             <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                count_r <= count_r + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
            end
        end
    end

    // Instruction memory: debug writes while loading, one synchronous read per issue.
    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            if (i_write_en) begin
                mem_r[i_addr_wr[IDX_W+1:2]] <= i_data;
            end
            if (issue_s) begin
                rdata_r <= mem_r[pc_r[IDX_W+1:2]];
            end
        end
    end

    assign o_valid       = (count_r != {CNT_W{1'b0}});
    assign o_instruction = o_valid ? fq_instr_r[rd_ptr_r] : {DATA_W{1'b0}};
    assign o_pc_plus_4   = o_valid ? fq_pc4_r[rd_ptr_r] : {ADDR_W{1'b0}};
    assign o_fq_count    = count_r;
`ifdef IF_HALT_DETECT_EN
    assign o_halted      = (state_r == ST_HALT);
`else
    assign o_halted      = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored (addresses wrap).
    assign unused_s = ^{i_addr_wr, pc_r};

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (default build, halt detection off).
module tb_if_fetch_queue;

    logic        clk;
    logic        i_reset;
    logic        i_clk_en;
    logic        i_id_ready;
    logic        i_pcsrc;
    logic [31:0] i_beq_dir;
    logic        i_jump;
    logic [31:0] i_jump_addr;
    logic        i_jumpSel;
    logic [31:0] i_jr_jump_addr;
    logic        i_write_en;
    logic [31:0] i_addr_wr;
    logic [31:0] i_data;
    logic        o_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus_4;
    logic [2:0]  o_fq_count;
    logic        o_halted;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_queue dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_clk_en       (i_clk_en),
        .i_id_ready     (i_id_ready),
        .i_pcsrc        (i_pcsrc),
        .i_beq_dir      (i_beq_dir),
        .i_jump         (i_jump),
        .i_jump_addr    (i_jump_addr),
        .i_jumpSel      (i_jumpSel),
        .i_jr_jump_addr (i_jr_jump_addr),
        .i_write_en     (i_write_en),
        .i_addr_wr      (i_addr_wr),
        .i_data         (i_data),
        .o_valid        (o_valid),
        .o_instruction  (o_instruction),
        .o_pc_plus_4    (o_pc_plus_4),
        .o_fq_count     (o_fq_count),
        .o_halted       (o_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        i_write_en = 1'b1;
        i_addr_wr  = addr;
        i_data     = data;
        step();
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
        check_eq({tag, "_valid"}, {63'd0, o_valid}, 64'd1);
        check_eq({tag, "_instr"}, {32'd0, o_instruction}, {32'd0, instr});
        check_eq({tag, "_pc4"}, {32'd0, o_pc_plus_4}, {32'd0, pc4});
    endtask

    task automatic clear_redirects();
        i_pcsrc   = 1'b0;
        i_jump    = 1'b0;
        i_jumpSel = 1'b0;
    endtask

    initial begin
        i_reset = 1'b0; i_clk_en = 1'b1; i_id_ready = 1'b0;
        i_pcsrc = 1'b0; i_beq_dir = 32'd0; i_jump = 1'b0; i_jump_addr = 32'd0;
        i_jumpSel = 1'b0; i_jr_jump_addr = 32'd0;
        i_write_en = 1'b0; i_addr_wr = 32'd0; i_data = 32'd0;
        #1;
        check_eq("rst_valid", {63'd0, o_valid}, 64'd0);
        check_eq("rst_instr", {32'd0, o_instruction}, 64'd0);
        check_eq("rst_pc4", {32'd0, o_pc_plus_4}, 64'd0);
        check_eq("rst_count", {61'd0, o_fq_count}, 64'd0);
        check_eq("rst_halted", {63'd0, o_halted}, 64'd0);
        step(); step();
        i_reset = 1'b1;

        // Load program: 0x11..0x88 at words 0..7, plus test words at 9, 10 and 255.
        for (int i = 0; i < 8; i++) begin
            load_word(32'(i * 4), 32'(8'h11 * (i + 1)));
        end
        load_word(32'h24, 32'hFFFF_FFFF);
        load_word(32'h28, 32'h0000_1234);
        load_word(32'h3FC, 32'hA5A5_A5A5);

        // Basic streaming after load release.
        i_write_en = 1'b0; i_id_ready = 1'b1;
        step();
        check_eq("start_e0_valid", {63'd0, o_valid}, 64'd0);
        step();
        check_eq("start_e1_valid", {63'd0, o_valid}, 64'd0);
        step();
        check_head("stream0", 32'h11, 32'h4);
        for (int k = 1; k < 5; k++) begin
            step();
            check_head("stream", 32'(8'h11 * (k + 1)), 32'(4 * (k + 1)));
        end

        // Backpressure: queue fills to 4 and drains in order.
        load_word(32'h0, 32'h11);
        i_write_en = 1'b0; i_id_ready = 1'b0;
        repeat (8) step();
        check_eq("full_count", {61'd0, o_fq_count}, 64'd4);
        check_head("full_head", 32'h11, 32'h4);
        i_id_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            check_head("drain", 32'(8'h11 * (k + 1)), 32'(4 * (k + 1)));
        end

        // Branch redirect flushes queue and drops in-flight word.
        i_pcsrc = 1'b1; i_beq_dir = 32'h10;
        step();
        clear_redirects();
        check_eq("br_flush_count", {61'd0, o_fq_count}, 64'd0);
        step();
        check_eq("br_r1_valid", {63'd0, o_valid}, 64'd0);
        step();
        check_head("br_target", 32'h55, 32'h14);

        // Priority: JR beats jump beats branch.
        i_jumpSel = 1'b1; i_jr_jump_addr = 32'h8;
        i_jump = 1'b1; i_jump_addr = 32'hC;
        i_pcsrc = 1'b1; i_beq_dir = 32'h4;
        step();
        clear_redirects();
        step(); step();
        check_head("prio", 32'h33, 32'hC);
        step();
        check_head("prio_next", 32'h44, 32'h10);

        // Async reset mid-fetch.
        i_reset = 1'b0;
        #1;
        check_eq("arst_valid", {63'd0, o_valid}, 64'd0);
        check_eq("arst_instr", {32'd0, o_instruction}, 64'd0);
        check_eq("arst_pc4", {32'd0, o_pc_plus_4}, 64'd0);
        check_eq("arst_count", {61'd0, o_fq_count}, 64'd0);
        step();
        i_reset = 1'b1;

        // Restart from 0 after reset, then freeze with clk_en low.
        step(); step();
        check_head("post_rst", 32'h11, 32'h4);
        step();
        check_head("pre_freeze", 32'h22, 32'h8);
        check_eq("pre_freeze_count", {61'd0, o_fq_count}, 64'd1);
        i_clk_en = 1'b0;
        repeat (5) step();
        check_head("frozen", 32'h22, 32'h8);
        check_eq("frozen_count", {61'd0, o_fq_count}, 64'd1);
        i_clk_en = 1'b1;
        step();
        check_head("resume", 32'h33, 32'hC);

        // Index wrap: 0x3FC then word 0.
        i_jumpSel = 1'b1; i_jr_jump_addr = 32'h3FC;
        step();
        clear_redirects();
        step(); step();
        check_head("wrap_top", 32'hA5A5_A5A5, 32'h400);
        step();
        check_head("wrap_zero", 32'h11, 32'h404);

        // PC+4 wraps modulo 2^32.
        i_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFC;
        step();
        clear_redirects();
        step(); step();
        check_head("pcwrap_top", 32'hA5A5_A5A5, 32'h0);
        step();
        check_head("pcwrap_zero", 32'h11, 32'h4);

        // Redirect during load is ignored; fetch restarts at 0.
        i_pcsrc = 1'b1; i_beq_dir = 32'h10;
        load_word(32'h20, 32'h99);
        clear_redirects();
        i_write_en = 1'b0;
        step(); step(); step();
        check_head("ld_prio", 32'h11, 32'h4);
        step();
        check_head("ld_prio_next", 32'h22, 32'h8);

        // Back-to-back redirects: latest wins.
        i_pcsrc = 1'b1; i_beq_dir = 32'h4;
        step();
        i_pcsrc = 1'b0; i_jump = 1'b1; i_jump_addr = 32'h10;
        step();
        clear_redirects();
        step(); step();
        check_head("b2b", 32'h55, 32'h14);

`ifndef IF_HALT_DETECT_EN
        // All-ones word is an ordinary instruction without halt detection.
        i_jump = 1'b1; i_jump_addr = 32'h24;
        step();
        clear_redirects();
        step(); step();
        check_head("ones", 32'hFFFF_FFFF, 32'h28);
        check_eq("ones_halted", {63'd0, o_halted}, 64'd0);
        step();
        check_head("ones_next", 32'h1234, 32'h2C);
        check_eq("ones_next_halted", {63'd0, o_halted}, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
